// File: rtl/hex_guess_entry_pkg.sv
// Shared widths, state encoding and edit-buffer opcodes for the guess entry path.
package hex_guess_entry_pkg;

  localparam int NUM_DIGITS = 4;
  localparam int DIGIT_W    = 4;
  localparam int GUESS_W    = NUM_DIGITS * DIGIT_W;
  localparam int CNT_W      = 3;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    PARTIAL = 2'd1,
    FULL    = 2'd2,
    OFFER   = 2'd3
  } state_e;

  // Operation applied to the edit buffer on the next edge.
  typedef enum logic [1:0] {
    SR_HOLD = 2'd0,
    SR_SHL  = 2'd1,
    SR_SHR  = 2'd2,
    SR_CLR  = 2'd3
  } sr_op_e;

endpackage

// File: rtl/hex_guess_entry_nibble_shift_reg.sv
// Nibble-wide edit buffer with a digit counter. The caller guarantees the
// counter never under/overflows (it gates SHL in FULL and SHR in EMPTY).
module nibble_shift_reg
  import hex_guess_entry_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  sr_op_e             i_op,
  input  logic [DIGIT_W-1:0] i_nibble,
  output logic [GUESS_W-1:0] o_data,
  output logic [CNT_W-1:0]   o_count
);

  logic [GUESS_W-1:0] r_data;
  logic [CNT_W-1:0]   r_count;

  // Apply the selected edit operation; newest digit always lives in [3:0].
  always_ff @(posedge clk) begin
    if (reset) begin
      r_data  <= '0;
      r_count <= '0;
    end else begin
      case (i_op)
        SR_SHL: begin
          r_data  <= {r_data[GUESS_W-DIGIT_W-1:0], i_nibble};
          r_count <= r_count + CNT_W'(1);
        end
        SR_SHR: begin
          r_data  <= {{DIGIT_W{1'b0}}, r_data[GUESS_W-1:DIGIT_W]};
          r_count <= r_count - CNT_W'(1);
        end
        SR_CLR: begin
          r_data  <= '0;
          r_count <= '0;
        end
        default: begin
          r_data  <= r_data;
          r_count <= r_count;
        end
      endcase
    end
  end

  assign o_data  = r_data;
  assign o_count = r_count;

endmodule

// File: rtl/hex_guess_entry.sv
// Hex guess entry: edits a four-digit buffer from user strobes and offers the
// completed guess downstream over valid/ready. All outputs are registered.
module hex_guess_entry
  import hex_guess_entry_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic [DIGIT_W-1:0] digit_in,
  input  logic               digit_valid,
  input  logic               backspace,
  input  logic               clear,
  input  logic               submit,
  input  logic               guess_ready,
  output logic [GUESS_W-1:0] guess_out,
  output logic               guess_valid,
  output logic [GUESS_W-1:0] entry_digits,
  output logic [CNT_W-1:0]   entry_count,
  output logic               reject
);

  state_e             r_state;
  state_e             w_state_nxt;
  sr_op_e             w_op;
  logic               w_reject_nxt;
  logic               w_load_guess;
  logic [GUESS_W-1:0] r_guess;
  logic               r_reject;
  logic [GUESS_W-1:0] w_buf;
  logic [CNT_W-1:0]   w_count;

  nibble_shift_reg u_buf (
    .clk      (clk),
    .reset    (reset),
    .i_op     (w_op),
    .i_nibble (digit_in),
    .o_data   (w_buf),
    .o_count  (w_count)
  );

  // State, offered guess and reject pulse registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= EMPTY;
      r_guess  <= '0;
      r_reject <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_reject <= w_reject_nxt;
      if (w_load_guess) r_guess <= w_buf;
    end
  end

  // Command arbitration (clear > submit > backspace > digit) and next state.
  // Only the winning command can reject; losers are dropped silently.
  always_comb begin
    w_state_nxt  = r_state;
    w_op         = SR_HOLD;
    w_reject_nxt = 1'b0;
    w_load_guess = 1'b0;
    if (r_state == OFFER) begin
      // Buffer is already empty here; every command is refused.
      w_reject_nxt = clear | submit | backspace | digit_valid;
      if (guess_ready) w_state_nxt = EMPTY;
    end else if (clear) begin
      w_op        = SR_CLR;
      w_state_nxt = EMPTY;
    end else if (submit) begin
      if (r_state == FULL) begin
        w_load_guess = 1'b1;
        w_op         = SR_CLR;
        w_state_nxt  = OFFER;
      end else begin
        w_reject_nxt = 1'b1;
      end
    end else if (backspace) begin
      if (r_state == EMPTY) begin
        w_reject_nxt = 1'b1;
      end else begin
        w_op        = SR_SHR;
        w_state_nxt = (w_count == CNT_W'(1)) ? EMPTY : PARTIAL;
      end
    end else if (digit_valid) begin
      if (r_state == FULL) begin
        w_reject_nxt = 1'b1;
      end else begin
        w_op        = SR_SHL;
        w_state_nxt = (w_count == CNT_W'(NUM_DIGITS - 1)) ? FULL : PARTIAL;
      end
    end
  end

  assign guess_out    = r_guess;
  assign guess_valid  = (r_state == OFFER);
  assign entry_digits = w_buf;
  assign entry_count  = w_count;
  assign reject       = r_reject;

endmodule

// File: tb/tb_hex_guess_entry.sv
module tb_hex_guess_entry;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  digit_in;
  logic        digit_valid, backspace, clear, submit, guess_ready;
  logic [15:0] guess_out, entry_digits;
  logic        guess_valid, reject;
  logic [2:0]  entry_count;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  hex_guess_entry dut (
    .clk(clk), .reset(reset), .digit_in(digit_in), .digit_valid(digit_valid),
    .backspace(backspace), .clear(clear), .submit(submit),
    .guess_ready(guess_ready), .guess_out(guess_out), .guess_valid(guess_valid),
    .entry_digits(entry_digits), .entry_count(entry_count), .reject(reject)
  );

  // Advance one edge; outputs are sampled 1 time unit after it.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    digit_valid = 0; backspace = 0; clear = 0; submit = 0;
  endtask

  task automatic put_digit(input logic [3:0] d);
    digit_in = d; digit_valid = 1;
    cyc();
    digit_valid = 0;
  endtask

  task automatic do_clear();
    clear = 1; cyc(); clear = 0; cyc();
  endtask

  task automatic test_reset();
    reset = 1; idle(); guess_ready = 0; digit_in = 4'h0;
    cyc(); cyc();
    reset = 0;
    checks++;
    if ({guess_out, guess_valid, entry_digits, entry_count, reject} !== 37'd0) begin
      failures++;
      $display("FAIL reset_outputs: got out=%h v=%b dig=%h cnt=%0d rej=%b expected all 0",
               guess_out, guess_valid, entry_digits, entry_count, reject);
    end
  endtask

  task automatic test_basic_submit();
    put_digit(4'hA); put_digit(4'h3); put_digit(4'h0); put_digit(4'hF);
    checks++;
    if (entry_digits !== 16'hA30F || entry_count !== 3'd4) begin
      failures++;
      $display("FAIL basic_fill: got %h/%0d expected a30f/4", entry_digits, entry_count);
    end
    guess_ready = 1; submit = 1; cyc(); submit = 0;
    checks++;
    if (guess_valid !== 1'b1 || guess_out !== 16'hA30F) begin
      failures++;
      $display("FAIL basic_offer: got v=%b out=%h expected v=1 out=a30f", guess_valid, guess_out);
    end
    checks++;
    if (entry_digits !== 16'h0 || entry_count !== 3'd0 || reject !== 1'b0) begin
      failures++;
      $display("FAIL basic_cleared: got dig=%h cnt=%0d rej=%b expected 0/0/0",
               entry_digits, entry_count, reject);
    end
    cyc();
    checks++;
    if (guess_valid !== 1'b0 || guess_out !== 16'hA30F) begin
      failures++;
      $display("FAIL basic_one_cycle: got v=%b out=%h expected v=0 out=a30f", guess_valid, guess_out);
    end
    guess_ready = 0;
  endtask

  task automatic test_edit();
    put_digit(4'h1); put_digit(4'h2); put_digit(4'h3);
    backspace = 1; cyc(); backspace = 0;
    checks++;
    if (entry_digits !== 16'h0012 || entry_count !== 3'd2) begin
      failures++;
      $display("FAIL edit_backspace: got %h/%0d expected 0012/2", entry_digits, entry_count);
    end
    put_digit(4'h7); put_digit(4'h9);
    checks++;
    if (entry_digits !== 16'h1279 || entry_count !== 3'd4 || reject !== 1'b0) begin
      failures++;
      $display("FAIL edit_fill: got %h/%0d rej=%b expected 1279/4 rej=0",
               entry_digits, entry_count, reject);
    end
    put_digit(4'h5);
    checks++;
    if (reject !== 1'b1 || entry_digits !== 16'h1279 || entry_count !== 3'd4) begin
      failures++;
      $display("FAIL edit_fifth_digit: got rej=%b %h/%0d expected rej=1 1279/4",
               reject, entry_digits, entry_count);
    end
    cyc();
    checks++;
    if (reject !== 1'b0) begin
      failures++;
      $display("FAIL edit_reject_pulse: got rej=%b expected 0", reject);
    end
    do_clear();
  endtask

  task automatic test_illegal();
    put_digit(4'hC); put_digit(4'hD);
    guess_ready = 1; submit = 1; cyc(); submit = 0;
    checks++;
    if (reject !== 1'b1 || guess_valid !== 1'b0 || entry_digits !== 16'h00CD
        || entry_count !== 3'd2) begin
      failures++;
      $display("FAIL early_submit: got rej=%b v=%b %h/%0d expected rej=1 v=0 00cd/2",
               reject, guess_valid, entry_digits, entry_count);
    end
    guess_ready = 0;
    do_clear();
    backspace = 1; cyc(); backspace = 0;
    checks++;
    if (reject !== 1'b1 || entry_count !== 3'd0 || entry_digits !== 16'h0) begin
      failures++;
      $display("FAIL empty_backspace: got rej=%b %h/%0d expected rej=1 0000/0",
               reject, entry_digits, entry_count);
    end
    cyc();
  endtask

  task automatic test_offer_hold();
    int bad = 0;
    put_digit(4'h5); put_digit(4'h5); put_digit(4'h5); put_digit(4'h5);
    guess_ready = 0; submit = 1; cyc(); submit = 0;
    for (int i = 0; i < 10; i++) begin
      digit_in = 4'h9;
      digit_valid = (i % 2 == 0);
      clear = (i % 2 == 1);
      cyc();
      if (guess_valid !== 1'b1 || guess_out !== 16'h5555 || reject !== 1'b1
          || entry_count !== 3'd0) bad++;
    end
    idle();
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL offer_hold: %0d of 10 cycles lost v=1/out=5555/rej=1/cnt=0 (last v=%b out=%h rej=%b)",
               bad, guess_valid, guess_out, reject);
    end
    guess_ready = 1; cyc();
    checks++;
    if (guess_valid !== 1'b0 || reject !== 1'b0) begin
      failures++;
      $display("FAIL offer_release: got v=%b rej=%b expected 0/0", guess_valid, reject);
    end
    guess_ready = 0;
    put_digit(4'h8);
    checks++;
    if (entry_digits !== 16'h0008 || entry_count !== 3'd1) begin
      failures++;
      $display("FAIL digit_after_transfer: got %h/%0d expected 0008/1", entry_digits, entry_count);
    end
    do_clear();
  endtask

  task automatic test_priority();
    put_digit(4'h1); put_digit(4'h2);
    clear = 1; digit_valid = 1; digit_in = 4'h6; cyc(); idle();
    checks++;
    if (entry_digits !== 16'h0 || entry_count !== 3'd0 || reject !== 1'b0) begin
      failures++;
      $display("FAIL clear_beats_digit: got %h/%0d rej=%b expected 0000/0 rej=0",
               entry_digits, entry_count, reject);
    end
    put_digit(4'h1); put_digit(4'h2); put_digit(4'h3); put_digit(4'h4);
    guess_ready = 1; submit = 1; backspace = 1; cyc(); idle();
    checks++;
    if (guess_valid !== 1'b1 || guess_out !== 16'h1234 || reject !== 1'b0
        || entry_count !== 3'd0) begin
      failures++;
      $display("FAIL submit_beats_backspace: got v=%b out=%h rej=%b cnt=%0d expected 1/1234/0/0",
               guess_valid, guess_out, reject, entry_count);
    end
    cyc();
    guess_ready = 0;
  endtask

  task automatic test_reset_in_offer();
    put_digit(4'h7); put_digit(4'h7); put_digit(4'h0); put_digit(4'h1);
    guess_ready = 0; submit = 1; cyc(); submit = 0;
    checks++;
    if (guess_valid !== 1'b1 || guess_out !== 16'h7701) begin
      failures++;
      $display("FAIL offer_before_reset: got v=%b out=%h expected 1/7701", guess_valid, guess_out);
    end
    digit_valid = 1; reset = 1; cyc(); digit_valid = 0; reset = 0;
    checks++;
    if ({guess_out, guess_valid, entry_digits, entry_count, reject} !== 37'd0) begin
      failures++;
      $display("FAIL reset_in_offer: got out=%h v=%b dig=%h cnt=%0d rej=%b expected all 0",
               guess_out, guess_valid, entry_digits, entry_count, reject);
    end
    put_digit(4'hB); put_digit(4'hE); put_digit(4'hE); put_digit(4'hF);
    guess_ready = 1; submit = 1; cyc(); submit = 0;
    checks++;
    if (guess_valid !== 1'b1 || guess_out !== 16'hBEEF) begin
      failures++;
      $display("FAIL post_reset_submit: got v=%b out=%h expected 1/beef", guess_valid, guess_out);
    end
    cyc();
    checks++;
    if (guess_valid !== 1'b0) begin
      failures++;
      $display("FAIL post_reset_release: got v=%b expected 0", guess_valid);
    end
  endtask

  initial begin
    test_reset();
    test_basic_submit();
    test_edit();
    test_illegal();
    test_offer_hold();
    test_priority();
    test_reset_in_offer();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hex_guess_entry.md
# hex_guess_entry

Upstream stage of `hex_guess_check`. Collects hex digits entered one at a time from debounced user-input strobes. Assembles them into a 16-bit, four-digit guess with backspace and clear editing. Offers the completed guess to the checker and game controller over a valid/ready handshake, holding the value stable until it is consumed.

## Interface
- `NUM_DIGITS`, 4: digits per guess. Only 4 is supported; it must match the checker.
- `DIGIT_W`, 4: bits per digit (hex).
- `clk`  in  1  system clock. All logic is on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `digit_in`  in  4  hex digit value. Sampled only when `digit_valid`=1.
- `digit_valid`  in  1  one-cycle strobe: append `digit_in`.
- `backspace`  in  1  one-cycle strobe: remove the most recently entered digit.
- `clear`  in  1  one-cycle strobe: discard all entered digits.
- `submit`  in  1  one-cycle strobe: offer the guess downstream.
- `guess_ready`  in  1  downstream is able to accept a guess.
- `guess_out`  out  16  offered guess. Digit 0 (most recently entered) is in [3:0].
- `guess_valid`  out  1  `guess_out` is valid and is being offered.
- `entry_digits`  out  16  live edit buffer, for the 7-segment display.
- `entry_count`  out  3  number of digits currently entered (0..4).
- `reject`  out  1  one-cycle pulse: the command was illegal in the current state.

## Operation
- States:
  - EMPTY: count = 0.
  - PARTIAL: count 1..3.
  - FULL: count = 4.
  - OFFER: `guess_valid` = 1.
- Reset value of every output is 0. After reset the state is EMPTY and the buffer is 0.
- Command priority within a cycle: `clear` > `submit` > `backspace` > `digit_valid`. Only the highest-priority asserted command is executed. Lower-priority commands in that cycle are dropped silently and do not cause `reject`.
- Digit (EMPTY/PARTIAL):
  - Buffer is shifted left by 4 bits; `digit_in` enters [3:0].
  - Count increments.
  - At count 4 the state goes to FULL.
- Digit in FULL: buffer unchanged, `reject` pulses.
- Backspace (PARTIAL/FULL):
  - Buffer is shifted right by 4 bits, zero-filled at [15:12].
  - Count decrements. Count 0 returns to EMPTY.
- Backspace in EMPTY: no change, `reject` pulses.
- Clear (EMPTY/PARTIAL/FULL): buffer becomes 0, count becomes 0, state goes to EMPTY. Never causes `reject`.
- Submit in FULL:
  - Buffer is copied to `guess_out`.
  - Next state is OFFER.
  - Buffer is zeroed and count is set to 0 in the same edge.
- Submit in EMPTY/PARTIAL: no change, `reject` pulses.
- OFFER:
  - `guess_valid` = 1 and `guess_out` is held constant.
  - All four commands are ignored and each one pulses `reject`.
  - When `guess_ready` = 1, the transfer completes at that edge. The next state is EMPTY and `guess_valid` falls.
- Leading-zero digits are legal and are not filtered. Zero-digit semantics belong to the checker.
- `guess_out` retains its last value after the transfer; it is only meaningful while `guess_valid` = 1.
- Reset in any state, including OFFER, forces the reset values. A pending offer is dropped with no handshake.

## Timing
- Every command takes effect at the edge where it is sampled. `entry_digits` and `entry_count` update in the following cycle.
- `reject` is registered: it is high during the cycle after the offending command.
- Submit sampled at edge N: `guess_valid` = 1 from cycle N+1.
- Minimum offer duration is 1 cycle. `guess_ready` may be held high permanently.
- `guess_valid` never depends combinationally on `guess_ready`. No outputs have combinational input-to-output paths.
- Digits may be entered on the cycle immediately after the transfer edge.
- Back-to-back strobes on consecutive cycles must all be honoured. Digit entry runs at up to one digit per cycle.

## Structure
- Shared package:
  - `NUM_DIGITS` and `DIGIT_W` constants.
  - `GUESS_W` = 16.
  - State enum {EMPTY, PARTIAL, FULL, OFFER}.
- The checker imports the same width constants.
- One sub-module, `nibble_shift_reg`: 16-bit register with shift-left-insert, shift-right-zero-fill, clear and hold controls, plus a 3-bit count. The top level holds the FSM, command arbitration, output register and `reject` generation.

## Test plan
- Reset, then digits A,3,0,F on consecutive cycles, then submit with `guess_ready`=1 → `guess_valid`=1 for exactly 1 cycle with `guess_out`=16'hA30F. Afterwards `entry_count`=0 and `entry_digits`=0.
- Digits 1,2,3, backspace, digit 7, digit 9 → `entry_digits`=16'h1279, count 4. A fifth digit then gives `reject`=1 and the buffer is unchanged.
- Submit with count 2 → `reject`=1, `guess_valid` stays 0 and the buffer is unchanged. A backspace when empty also gives `reject`.
- Offer 16'h5555 with `guess_ready`=0 for 10 cycles while digit and clear strobes are applied → `guess_out` is stable, `guess_valid` stays 1, and each strobe pulses `reject`. Raising `guess_ready` completes the transfer in 1 cycle.
- Same-cycle `clear`+`digit_valid` in PARTIAL → buffer 0, count 0, no `reject`. Same-cycle `submit`+`backspace` in FULL → submit wins.
- Assert `reset` while in OFFER → the next cycle has all outputs 0 and state EMPTY. A subsequent full entry and submit works normally.
